// File: rtl/tape_load_sequencer.sv
// tape_load_sequencer: loads symbols onto a tape, then starts and paces a machine until it halts or times out
module tape_load_sequencer #(
    parameter int DATA_W = 4,
    parameter int TAPE_LEN = 64,
    parameter int MAX_STEPS = 4095,
    localparam int ADDR_W = $clog2(TAPE_LEN)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              next,
    input  logic              done,
    input  logic              step_mode,
    input  logic              tm_halted,
    output logic              tm_wr_en,
    output logic [ADDR_W-1:0] tm_wr_addr,
    output logic [DATA_W-1:0] tm_wr_data,
    output logic              tm_start,
    output logic              tm_step,
    output logic [ADDR_W:0]   load_count,
    output logic [11:0]       step_count,
    output logic [1:0]        status,
    output logic              compute_done
);
    typedef enum logic [2:0] {LOAD, START, RUN, HALTED, TIMEOUT} state_t;
    state_t state, state_n;
    logic next_s, next_h, done_s, done_h;
    logic next_ev, done_ev, full, wr_go, step_go;

    always_comb begin
        next_ev = next_s & ~next_h;
        done_ev = done_s & ~done_h;
        full = load_count == (ADDR_W+1)'(TAPE_LEN);
        state_n = state;
        wr_go = 1'b0;
        step_go = 1'b0;
        case (state)
            LOAD: begin
                state_n = done_ev ? START : LOAD;
                wr_go = next_ev & ~done_ev & ~full;
            end
            START: state_n = RUN;
            RUN: begin
                if (done_ev) state_n = LOAD;
                else if (tm_halted) state_n = HALTED;
                else if (step_count == 12'(MAX_STEPS)) state_n = TIMEOUT;
                else step_go = step_mode ? next_ev : 1'b1;
            end
            HALTED, TIMEOUT: state_n = done_ev ? LOAD : state;
            default: state_n = LOAD;
        endcase
    end

    // button history resets high so a button held through reset yields no event
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD;
            {next_s, next_h, done_s, done_h} <= 4'b1111;
            tm_wr_en <= 1'b0;
            tm_wr_addr <= '0;
            tm_wr_data <= '0;
            tm_start <= 1'b0;
            tm_step <= 1'b0;
            load_count <= '0;
            step_count <= '0;
            status <= 2'b00;
            compute_done <= 1'b0;
        end else begin
            next_s <= next;
            next_h <= next_s;
            done_s <= done;
            done_h <= done_s;
            state <= state_n;
            tm_wr_en <= wr_go;
            tm_start <= state == START;
            tm_step <= step_go;
            if (wr_go) begin
                tm_wr_addr <= load_count[ADDR_W-1:0];
                tm_wr_data <= data_in;
                load_count <= load_count + (ADDR_W+1)'(1);
            end
            if (state_n == LOAD && state != LOAD) load_count <= '0;
            if (state == START) step_count <= '0;
            else if (step_go) step_count <= step_count + 12'd1;
            status <= state_n == HALTED ? 2'b10 : state_n == TIMEOUT ? 2'b11 : state_n == LOAD ? 2'b00 : 2'b01;
            compute_done <= state_n == HALTED || state_n == TIMEOUT;
        end
    end
endmodule

// File: tb/tb_tape_load_sequencer.sv
// tb_tape_load_sequencer: directed stimulus with a strobe scoreboard for tape_load_sequencer
module tb_tape_load_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] data_in = '0;
    logic next = 1'b0, done = 1'b0, step_mode = 1'b0, tm_halted = 1'b0;
    logic tm_wr_en, tm_start, tm_step, compute_done;
    logic [5:0] tm_wr_addr;
    logic [3:0] tm_wr_data;
    logic [6:0] load_count;
    logic [11:0] step_count;
    logic [1:0] status;
    int errors = 0, checks = 0;
    int halt_at = 0, run_steps = 0;

    typedef struct {int kind; logic [5:0] addr; logic [3:0] data;} ev_t;
    ev_t q[$];
    localparam int WR = 0, ST = 1, SP = 2;

    tape_load_sequencer #(.DATA_W(4), .TAPE_LEN(64), .MAX_STEPS(20)) dut (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .next(next), .done(done),
        .step_mode(step_mode), .tm_halted(tm_halted), .tm_wr_en(tm_wr_en),
        .tm_wr_addr(tm_wr_addr), .tm_wr_data(tm_wr_data), .tm_start(tm_start),
        .tm_step(tm_step), .load_count(load_count), .step_count(step_count),
        .status(status), .compute_done(compute_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [5:0] a, input logic [3:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [5:0] a, input logic [3:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected strobe: got kind %0d addr %0d data %0d, expected none", kind, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind == WR && (e.addr != a || e.data != d))) begin
                errors++;
                $display("FAIL strobe: got kind %0d addr %0d data %0d, expected kind %0d addr %0d data %0d",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // monitor: pops the scoreboard on every strobe and models the machine halting
    always @(negedge clock) begin
        if (tm_wr_en || tm_start || tm_step) begin
            checks++;
            if ({1'b0, tm_wr_en} + {1'b0, tm_start} + {1'b0, tm_step} > 2'd1) begin
                errors++;
                $display("FAIL exclusive strobes: got wr %0b start %0b step %0b, expected one", tm_wr_en, tm_start, tm_step);
            end
        end
        if (tm_wr_en) pop_check(WR, tm_wr_addr, tm_wr_data);
        if (tm_start) begin
            pop_check(ST, '0, '0);
            run_steps = 0;
            tm_halted = 1'b0;
        end
        if (tm_step) begin
            pop_check(SP, '0, '0);
            run_steps++;
            if (halt_at != 0 && run_steps == halt_at) tm_halted = 1'b1;
        end
    end

    task automatic press(input logic n, input logic d, input logic [3:0] v);
        @(negedge clock);
        data_in = v; next = n; done = d;
        repeat (2) @(negedge clock);
        next = 1'b0; done = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !compute_done; i++) @(negedge clock);
    endtask

    task automatic drained(input string name);
        check(name, q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1;
        check("reset wr_en", tm_wr_en, 0);
        check("reset start", tm_start, 0);
        check("reset step", tm_step, 0);
        check("reset addr", tm_wr_addr, 0);
        check("reset data", tm_wr_data, 0);
        check("reset load_count", load_count, 0);
        check("reset step_count", step_count, 0);
        check("reset status", status, 0);
        check("reset compute_done", compute_done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        push(WR, 0, 5); press(1, 0, 5);
        push(WR, 1, 9); press(1, 0, 9);
        push(WR, 2, 2); press(1, 0, 2);
        check("load3 load_count", load_count, 3);
        drained("load3 drained");

        halt_at = 10;
        push(ST, 0, 0);
        for (int i = 0; i < 10; i++) push(SP, 0, 0);
        press(0, 1, 0);
        wait_done();
        repeat (3) @(negedge clock);
        check("halt status", status, 2);
        check("halt compute_done", compute_done, 1);
        check("halt step_count", step_count, 10);
        drained("halt drained");
        press(1, 0, 0);
        check("halted ignores next", status, 2);
        drained("halted next drained");

        press(0, 1, 0);
        check("reload status", status, 0);
        check("reload load_count", load_count, 0);
        check("reload keeps step_count", step_count, 10);
        for (int i = 0; i < 65; i++) begin
            if (i < 64) push(WR, 6'(i), 4'(i));
            press(1, 0, 4'(i));
        end
        check("full load_count", load_count, 64);
        drained("full drained");

        halt_at = 0;
        push(ST, 0, 0);
        for (int i = 0; i < 20; i++) push(SP, 0, 0);
        press(0, 1, 0);
        wait_done();
        repeat (3) @(negedge clock);
        check("timeout status", status, 3);
        check("timeout compute_done", compute_done, 1);
        check("timeout step_count", step_count, 20);
        drained("timeout drained");
        press(1, 0, 0);
        check("timeout holds step_count", step_count, 20);
        drained("timeout next drained");

        press(0, 1, 0);
        step_mode = 1'b1;
        push(ST, 0, 0);
        press(1, 1, 4'd3);
        check("both status", status, 1);
        check("both load_count", load_count, 0);
        drained("both drained");
        repeat (4) @(negedge clock);
        check("single step idle", step_count, 0);
        for (int i = 0; i < 3; i++) begin
            push(SP, 0, 0);
            press(1, 0, 0);
        end
        check("single step_count", step_count, 3);
        check("single status", status, 1);
        drained("single drained");

        push(SP, 0, 0);
        @(negedge clock);
        next = 1'b1;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrun status", status, 0);
        check("midrun step", tm_step, 0);
        check("midrun step_count", step_count, 0);
        check("midrun compute_done", compute_done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("after reset status", status, 0);
        check("after reset load_count", load_count, 0);
        drained("after reset drained");
        next = 1'b0;
        repeat (2) @(negedge clock);
        push(WR, 0, 7);
        press(1, 0, 7);
        check("post reset load_count", load_count, 1);
        drained("post reset drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tape_load_sequencer.md
TAPE_LOAD_SEQUENCER -- requirements
Module: tape_load_sequencer

Interface
REQ-001 Parameter DATA_W, default 4, tape symbol width in bits.
REQ-002 Parameter TAPE_LEN, default 64, tape cells; power of two; ADDR_W = log2(TAPE_LEN).
REQ-003 Parameter MAX_STEPS, default 4095, run-step limit; fits 12 bits.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  DATA_W  symbol to write to the tape during load.
REQ-007 next  input  1  Next button, already synchronized, level.
REQ-008 done  input  1  Done button, already synchronized, level.
REQ-009 step_mode  input  1  1 = single-step run, 0 = free run.
REQ-010 tm_halted  input  1  machine has reached its halt state, level.
REQ-011 tm_wr_en  output  1  tape write strobe.
REQ-012 tm_wr_addr  output  ADDR_W  tape write address.
REQ-013 tm_wr_data  output  DATA_W  tape write data.
REQ-014 tm_start  output  1  one-cycle pulse that resets the head and state of the machine.
REQ-015 tm_step  output  1  advance the machine one step this cycle.
REQ-016 load_count  output  ADDR_W+1  number of cells written since the last LOAD entry.
REQ-017 step_count  output  12  steps issued in the current run.
REQ-018 status  output  2  00 LOAD, 01 RUN, 10 HALTED, 11 TIMEOUT.
REQ-019 compute_done  output  1  high in HALTED or TIMEOUT.

Function
REQ-020 Internal rising-edge detectors on next and done shall produce single-cycle events next_ev and done_ev, one cycle after the input rises.
REQ-021 States: LOAD, START, RUN, HALTED, TIMEOUT.
REQ-022 LOAD, next_ev, load_count < TAPE_LEN: the block shall assert tm_wr_en for one cycle with tm_wr_addr = load_count[ADDR_W-1:0] and tm_wr_data = data_in, then increment load_count.
REQ-023 LOAD, next_ev, load_count == TAPE_LEN (full): no write; load_count holds.
REQ-024 LOAD, done_ev: transition to START; done_ev wins over a simultaneous next_ev, and no write occurs that cycle.
REQ-025 START: tm_start = 1 for exactly one cycle; clear step_count; transition to RUN.
REQ-026 RUN, step_mode = 0: tm_step = 1 every cycle that tm_halted = 0.
REQ-027 RUN, step_mode = 1: tm_step = 1 for one cycle per next_ev, only while tm_halted = 0.
REQ-028 step_count shall increment on every cycle with tm_step = 1.
REQ-029 RUN, tm_halted = 1: tm_step = 0 that cycle; transition to HALTED.
REQ-030 RUN, step_count == MAX_STEPS and tm_halted = 0: tm_step = 0; transition to TIMEOUT.
REQ-031 If the halted and timeout conditions occur in the same cycle, HALTED shall win.
REQ-032 RUN, done_ev: abort; transition to LOAD.
REQ-033 HALTED or TIMEOUT: outputs hold; next_ev ignored; done_ev returns to LOAD.
REQ-034 Every LOAD entry shall clear load_count and preserve step_count; tape contents are not cleared, and new loads overwrite from address 0.
REQ-035 step_mode may change at any time and shall take effect on the next cycle.
REQ-036 tm_wr_en, tm_start and tm_step are mutually exclusive in every cycle.
REQ-037 All outputs shall be registered, with no combinational path from inputs to outputs.

Reset
REQ-038 reset_n low: immediate entry to LOAD; load_count = 0; step_count = 0; tm_wr_en, tm_start and tm_step = 0; tm_wr_addr = 0; tm_wr_data = 0; status = 00; compute_done = 0.
REQ-039 The edge detectors shall reset their history to 1, so that a button held through reset does not generate an event.
REQ-040 Reset asserted mid-RUN shall abort the run with no further tm_step; release returns the block to LOAD.

Verification
REQ-041 Load 3 symbols: data_in 5, 9, 2, each with one next press -> writes at addresses 0, 1, 2 with data 5, 9, 2; load_count = 3.
REQ-042 65 next presses with TAPE_LEN = 64 -> exactly 64 writes; load_count = 64; the 65th press produces no tm_wr_en.
REQ-043 done press, step_mode = 0, tm_halted raised after 10 steps -> one tm_start pulse, 10 tm_step cycles, status = 10, compute_done = 1, step_count = 10.
REQ-044 Free run, tm_halted held 0, MAX_STEPS = 20 -> exactly 20 steps; status = 11; step_count = 20.
REQ-045 step_mode = 1, three next presses -> exactly three single-cycle tm_step pulses; next and done rising in the same cycle in LOAD -> START entered, no write.
REQ-046 reset_n pulsed low during RUN with next held high -> outputs match REQ-038 at once; no write or step after release until a new next edge.
